// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - decode-side {pc, instr} valid/ready bundle for fetch_queue
interface fetch_queue_if;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [31:0] out_pc;

   modport master (output out_valid, output out_instr, output out_pc, input out_ready);
   modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - RV32I fetch PC, ROM addressing and {pc, instr} prefetch FIFO
// Optional misaligned-redirect trap enabled by `define FETCH_MISALIGN_TRAP_EN
module fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] rom_addr,
   input  logic [31:0] rom_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
`ifdef FETCH_MISALIGN_TRAP_EN
   output logic        fetch_fault,
`endif
   fetch_queue_if.master out_if
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [31:0]   fetch_pc;
   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic          pop;
   logic          push;
   logic          fault_stop;
   logic [31:0]   target_pc;

`ifdef FETCH_MISALIGN_TRAP_EN
   logic fault_q;

   assign fetch_fault = fault_q;
   assign fault_stop  = fault_q;
   assign target_pc   = redirect_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_q <= 1'b0;
      end else if (redirect_valid) begin
         fault_q <= |redirect_pc[1:0];
      end
   end
`else
   assign fault_stop = 1'b0;
   // Without the trap, misaligned targets are silently word-aligned.
   assign target_pc  = redirect_pc & 32'hFFFF_FFFC;
`endif

   assign rom_addr         = fetch_pc;
   assign out_if.out_valid = (count != '0);
   assign out_if.out_pc    = mem[rd_ptr][63:32];
   assign out_if.out_instr = mem[rd_ptr][31:0];

   // A redirect discards both the pop and the push of its cycle.
   always_comb begin
      pop  = 1'b0;
      push = 1'b0;
      pop  = out_if.out_valid && out_if.out_ready && !redirect_valid;
      push = !redirect_valid && !fault_stop && ((count < FULL) || pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc <= RESET_PC;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (redirect_valid) begin
         fetch_pc <= target_pc;
         count    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {fetch_pc, rom_data};
            wr_ptr      <= wr_ptr + AW'(1);
            fetch_pc    <= fetch_pc + 32'd4;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed scoreboard bench for fetch_queue (DEPTH=2, RESET_PC=0)
module tb_fetch_queue;
   logic        clk;
   logic        rst_n;
   logic [31:0] rom_addr;
   logic [31:0] rom_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
   logic        fetch_fault;
`endif
   int          total;
   int          bad;
   logic [31:0] sb[$];

   fetch_queue_if fq ();

   fetch_queue #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rom_addr       (rom_addr),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
`ifdef FETCH_MISALIGN_TRAP_EN
      .fetch_fault    (fetch_fault),
`endif
      .out_if         (fq)
   );

   // ROM word at index i holds the value i.
   assign rom_data = rom_addr >> 2;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_range(input logic [31:0] start, input int n);
      for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
   endtask

   // Score any handshake that will complete at the coming edge, then advance one cycle.
   task automatic tick();
      logic [31:0] e;
      @(negedge clk);
      if (fq.out_valid && fq.out_ready && !redirect_valid) begin
         total++;
         assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL pop_unexpected observed=%h expected=none", fq.out_pc);
         end
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("pop_pc", fq.out_pc, e);
            chk("pop_instr", fq.out_instr, e >> 2);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      sb.delete();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      fq.out_ready   = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      #3;
      chk("rst_valid", 32'(fq.out_valid), 32'h0);
      chk("rst_pc", fq.out_pc, 32'h0);
      chk("rst_instr", fq.out_instr, 32'h0);
      chk("rst_rom_addr", rom_addr, 32'h0);
      push_range(32'h0, 40);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      tick();
      chk("first_valid", 32'(fq.out_valid), 32'h1);
      chk("first_pc", fq.out_pc, 32'h0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("stream_valid", 32'(fq.out_valid), 32'h1);
      end

      rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(fq.out_valid), 32'h0);
      chk("async_pc", fq.out_pc, 32'h0);
      chk("async_instr", fq.out_instr, 32'h0);
      chk("async_rom_addr", rom_addr, 32'h0);
      sb.delete();
      fq.out_ready = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      push_range(32'h0, 40);
      for (int i = 0; i < 5; i++) begin
         tick();
         if (i >= 1) chk("stall_rom_addr", rom_addr, 32'h8);
      end
      chk("stall_valid", 32'(fq.out_valid), 32'h1);
      chk("stall_pc", fq.out_pc, 32'h0);
      fq.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("release_valid", 32'(fq.out_valid), 32'h1);
      end

      // Redirect while full, with a pop requested in the same cycle.
      fq.out_ready = 1'b0;
      tick();
      tick();
      fq.out_ready = 1'b1;
      redirect(32'h100);
      push_range(32'h100, 40);
      tick();
      redirect_valid = 1'b0;
      chk("redir_gap", 32'(fq.out_valid), 32'h0);
      tick();
      chk("redir_valid", 32'(fq.out_valid), 32'h1);
      chk("redir_pc0", fq.out_pc, 32'h100);
      tick();
      chk("redir_pc1", fq.out_pc, 32'h104);
      for (int i = 0; i < 3; i++) tick();

      redirect(32'hFFFF_FFFC);
      push_range(32'hFFFF_FFFC, 20);
      tick();
      redirect_valid = 1'b0;
      tick();
      chk("wrap_pc0", fq.out_pc, 32'hFFFF_FFFC);
      tick();
      chk("wrap_pc1", fq.out_pc, 32'h0);
      tick();
      tick();

      redirect(32'h300);
      tick();
      redirect(32'h400);
      push_range(32'h400, 20);
      tick();
      redirect_valid = 1'b0;
      chk("b2b_gap", 32'(fq.out_valid), 32'h0);
      tick();
      chk("b2b_pc", fq.out_pc, 32'h400);
      tick();
      tick();

      redirect(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
      tick();
      redirect_valid = 1'b0;
      chk("fault_set", 32'(fetch_fault), 32'h1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("fault_no_push", 32'(fq.out_valid), 32'h0);
         chk("fault_rom_addr", rom_addr, 32'h102);
      end
      redirect(32'h200);
      push_range(32'h200, 20);
      tick();
      redirect_valid = 1'b0;
      chk("fault_clear", 32'(fetch_fault), 32'h0);
      tick();
      chk("fault_resume_pc", fq.out_pc, 32'h200);
      tick();
      tick();
`else
      push_range(32'h100, 20);
      tick();
      redirect_valid = 1'b0;
      tick();
      chk("align_pc", fq.out_pc, 32'h100);
      chk("align_instr", fq.out_instr, 32'h40);
      tick();
      tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch stage for the single-issue RV32I core. Holds the fetch PC, drives the word address of the combinational instruction ROM, and captures the returned word together with its PC into a small prefetch FIFO. Decode consumes `{pc, instr}` pairs through a valid/ready handshake, and a branch/jump redirect flushes the queue and restarts fetch.

## Interface
- `RESET_PC`, 32'h0000_0000: fetch PC loaded on reset.
- `DEPTH`, 2: FIFO entries; power of two, 2..8.
- `clk`  in  1  single clock; all state on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rom_addr`  out  32  byte address to the instruction ROM; always equals `fetch_pc`.
- `rom_data`  in  32  instruction word; combinational response to `rom_addr`, valid in the same cycle.
- `redirect_valid`  in  1  single-cycle redirect request from execute.
- `redirect_pc`  in  32  new fetch target, sampled when `redirect_valid`=1.
- `out_valid`  out  1  FIFO head holds a valid instruction.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  32  head instruction word.
- `out_pc`  out  32  PC of the head instruction.
- `fetch_fault`  out  1  sticky misaligned-target flag; present only with `FETCH_MISALIGN_TRAP_EN`.

## Operation
- State: `fetch_pc` (32b), FIFO storage of `DEPTH` × 64b `{pc, instr}`, read/write pointers, and a count of width clog2(`DEPTH`)+1.
- Pop: `out_valid && out_ready`.
- Push: `count < DEPTH`, or `count == DEPTH` with a pop in the same cycle. A push writes `{fetch_pc, rom_data}` and sets `fetch_pc <= fetch_pc + 4` (mod 2^32; 32'hFFFF_FFFC wraps to 0).
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Redirect has priority over push and pop in the same cycle:
  - count is cleared to 0 and pointers are reset; any pending pop is discarded.
  - `fetch_pc <= redirect_pc`; no push occurs that cycle.
- Back-to-back redirects: the last sampled redirect wins.
- `out_valid` = (count != 0). `out_instr`/`out_pc` come from the head entry and stay stable while `out_valid && !out_ready`.
- Pointers wrap modulo `DEPTH`.
- Reset (asynchronous, any time, including mid-stream):
  - `fetch_pc`=`RESET_PC`; count, pointers and `fetch_fault` = 0.
  - `out_valid`=0, `out_instr`=0, `out_pc`=0 (storage cleared to 0).
  - `rom_addr`=`RESET_PC`.

## Timing
- `rom_addr` is a direct register output; `rom_data` is sampled at the same edge that advances `fetch_pc`.
- After reset release: first push on the first edge; `out_valid`=1 after that edge, with `out_pc`=`RESET_PC`.
- Sustained throughput: 1 instruction/cycle while `out_ready`=1.
- Redirect latency: `out_valid`=0 for exactly one cycle after the redirect edge. The target instruction appears after the next edge.
- Full with `out_ready`=0: `fetch_pc` and `rom_addr` hold; no ROM word is lost or duplicated.

## Configuration
- Macro: `FETCH_MISALIGN_TRAP_EN`.
- Defined:
  - A redirect with `redirect_pc[1:0] != 0` sets `fetch_fault`=1 and loads `fetch_pc` with the value as given.
  - Pushes stop until reset or a subsequent aligned redirect; an aligned redirect clears `fetch_fault`.
- Undefined:
  - `fetch_fault` port absent.
  - `redirect_pc[1:0]` is forced to 2'b00 on load, so all fetches stay word-aligned.

## Test plan
- Reset with `RESET_PC`=0, ROM word[i]=i, `out_ready`=1 → `out_pc` sequence 0,4,8,…; `out_instr` 0,1,2,…; `out_valid` continuous from cycle 1.
- Hold `out_ready`=0 for 5 cycles with `DEPTH`=2 → count saturates at 2 and `rom_addr` holds at 8. Then release → pcs 0,4,8,… delivered with no gap or duplicate.
- Redirect to 32'h100 while the queue holds 0x4,0x8 → exactly one cycle of `out_valid`=0, then `out_pc`=32'h100 then 32'h104; 0x4 and 0x8 are never delivered.
- Redirect and pop in the same cycle with the queue full → the pop is discarded and count=0 next cycle, then refetch from the target.
- Redirect to 32'hFFFF_FFFC → `out_pc` 32'hFFFF_FFFC, then 32'h0.
- Redirect to 32'h102: with the macro, `fetch_fault`=1 and no pushes until an aligned redirect to 32'h200 clears it; without the macro, `out_pc`=32'h100.
- Assert `rst_n`=0 mid-stream → all outputs 0 and `rom_addr`=`RESET_PC` immediately, without waiting for a clock edge.
